// File: rtl/reg_file_pkg.sv
// Shared constants and types for the RV32I integer register file.
package reg_file_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef logic [XLEN-1:0] word_t;
    typedef logic [AW-1:0]   reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage : reg_file_pkg

// File: rtl/reg_file_read_port.sv
// One combinational read port of the register file: x0 masking plus,
// when REG_FILE_BYPASS_EN is defined, write-through forwarding of the
// word being written this cycle.
module reg_file_read_port
    import reg_file_pkg::*;
(
    input  reg_addr_t addr,
    input  word_t     regs [NREGS],
    input  logic      rst,
    input  logic      we,
    input  reg_addr_t wraddr,
    input  word_t     wrdata,
    output word_t     rdout
);

`ifdef REG_FILE_BYPASS_EN
    logic fwd_hit;

    // Forward only a write that will really land: not during reset, not to x0.
    assign fwd_hit = !rst && we && (wraddr != REG_ZERO) && (addr == wraddr);

    // x0 always reads zero; otherwise the in-flight write wins over storage.
    always_comb begin
        rdout = regs[addr];
        if (addr == REG_ZERO) begin
            rdout = '0;
        end else if (fwd_hit) begin
            rdout = wrdata;
        end
    end
`else
    // Write-port signals only matter for forwarding; gather them so they are
    // visibly consumed in the plain build.
    logic unused_wr_sigs;
    assign unused_wr_sigs = &{1'b0, rst, we, wraddr, wrdata};

    // x0 always reads zero; otherwise a plain storage read (pre-write contents).
    always_comb begin
        rdout = regs[addr];
        if (addr == REG_ZERO) begin
            rdout = '0;
        end
    end
`endif

endmodule : reg_file_read_port

// File: rtl/reg_file.sv
// RV32I integer register file: 32 x 32-bit, two asynchronous read ports,
// one synchronous write port, x0 hardwired to zero.
// Optional feature macro: REG_FILE_BYPASS_EN (same-cycle write forwarding).
module reg_file
    import reg_file_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic [AW-1:0]    wraddr,
    input  logic [XLEN-1:0]  wrdata,
    output logic [XLEN-1:0]  rdout1,
    output logic [XLEN-1:0]  rdout2
);

    // Read-side view of the whole register set; entry 0 is a constant zero.
    word_t regs_view [NREGS];

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                // x0 has no storage at all.
                assign regs_view[gi] = '0;
            end else begin : g_store
                localparam reg_addr_t IDX = reg_addr_t'(gi);
                word_t q_reg;

                // Clear on reset (reset beats a write), else load on a matching write.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        q_reg <= '0;
                    end else if (we && (wraddr == IDX)) begin
                        q_reg <= wrdata;
                    end
                end

                assign regs_view[gi] = q_reg;
            end
        end
    endgenerate

    reg_file_read_port u_port1 (
        .addr   (rs1),
        .regs   (regs_view),
        .rst    (rst),
        .we     (we),
        .wraddr (wraddr),
        .wrdata (wrdata),
        .rdout  (rdout1)
    );

    reg_file_read_port u_port2 (
        .addr   (rs2),
        .regs   (regs_view),
        .rst    (rst),
        .we     (we),
        .wraddr (wraddr),
        .wrdata (wrdata),
        .rdout  (rdout2)
    );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, hand-written
// same-cycle / reset-priority sequences, then randomized traffic against
// a simple array model of the register file.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  wraddr;
    logic [31:0] wrdata;
    logic [31:0] rdout1;
    logic [31:0] rdout2;

    int total = 0;
    int bad   = 0;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    reg_file dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .rs1    (rs1),
        .rs2    (rs2),
        .wraddr (wraddr),
        .wrdata (wrdata),
        .rdout1 (rdout1),
        .rdout2 (rdout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    typedef struct {
        logic        v_rst;
        logic        v_we;
        logic [4:0]  v_wraddr;
        logic [31:0] v_wrdata;
        logic [4:0]  v_rs1;
        logic [4:0]  v_rs2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [6];

    // Reference model: plain array, x0 forced to zero on every read.
    logic [31:0] model [32];

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic r,
                                               input logic w, input logic [4:0] wa,
                                               input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (BYPASS && !r && w && wa == a) return wd;
        return model[a];
    endfunction

    initial begin
        rst = 1'b0; we = 1'b0; rs1 = '0; rs2 = '0; wraddr = '0; wrdata = '0;

        vecs[0] = '{1'b1, 1'b0, 5'd0, 32'h0,          5'd5, 5'd31, 32'h0,          32'h0};
        vecs[1] = '{1'b0, 1'b1, 5'd1, 32'h1234_5678,  5'd1, 5'd0,  32'h1234_5678,  32'h0};
        vecs[2] = '{1'b0, 1'b1, 5'd2, 32'h8765_4321,  5'd1, 5'd2,  32'h1234_5678,  32'h8765_4321};
        vecs[3] = '{1'b0, 1'b1, 5'd0, 32'hABCD_EF01,  5'd0, 5'd1,  32'h0,          32'h1234_5678};
        vecs[4] = '{1'b0, 1'b1, 5'd3, 32'h5555_5555,  5'd3, 5'd3,  32'h5555_5555,  32'h5555_5555};
        vecs[5] = '{1'b0, 1'b0, 5'd1, 32'hFFFF_FFFF,  5'd1, 5'd2,  32'h1234_5678,  32'h8765_4321};

        @(posedge clk); #1;

        // Directed table: drive write-side, one edge, then read back.
        for (int i = 0; i < 6; i++) begin
            rst = vecs[i].v_rst; we = vecs[i].v_we;
            wraddr = vecs[i].v_wraddr; wrdata = vecs[i].v_wrdata;
            @(posedge clk); #1;
            rst = 1'b0; we = 1'b0;
            rs1 = vecs[i].v_rs1; rs2 = vecs[i].v_rs2;
            #1;
            check($sformatf("vec%0d_rd1", i), rdout1, vecs[i].exp1);
            check($sformatf("vec%0d_rd2", i), rdout2, vecs[i].exp2);
        end

        // Same-cycle read of the register being written.
        we = 1'b1; wraddr = 5'd3; wrdata = 32'hAAAA_AAAA; rs1 = 5'd3; rs2 = 5'd0;
        #2;
        check("samecyc_pre", rdout1, BYPASS ? 32'hAAAA_AAAA : 32'h5555_5555);
        check("samecyc_x0", rdout2, 32'h0);
        @(posedge clk); #1;
        we = 1'b0;
        #1;
        check("samecyc_post", rdout1, 32'hAAAA_AAAA);

        // Write to x0 while reading x0: never forwarded.
        we = 1'b1; wraddr = 5'd0; wrdata = 32'hDEAD_BEEF; rs1 = 5'd0; rs2 = 5'd2;
        #1;
        check("x0_wr_pre", rdout1, 32'h0);
        check("x0_wr_other", rdout2, 32'h8765_4321);
        @(posedge clk); #1;
        we = 1'b0;

        // Reset together with a write: reset wins, forwarding suppressed.
        rst = 1'b1; we = 1'b1; wraddr = 5'd4; wrdata = 32'hCAFE_F00D; rs1 = 5'd4; rs2 = 5'd1;
        #1;
        check("rstwr_pre_fwd", rdout1, 32'h0);
        check("rstwr_pre_x1", rdout2, 32'h1234_5678);
        @(posedge clk); #1;
        rst = 1'b0; we = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rs1 = 5'(a); rs2 = 5'(31 - a);
            #1;
            check($sformatf("clr_rd1_x%0d", a), rdout1, 32'h0);
            check($sformatf("clr_rd2_x%0d", 31 - a), rdout2, 32'h0);
        end

        // Randomized traffic against the model (state is all-zero here).
        for (int a = 0; a < 32; a++) model[a] = 32'h0;
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom_range(0, 49) == 0);
            we     = ($urandom_range(0, 3) != 0);
            wraddr = 5'($urandom_range(0, 31));
            wrdata = $urandom;
            rs1    = ($urandom_range(0, 3) == 0) ? wraddr : 5'($urandom_range(0, 31));
            rs2    = 5'($urandom_range(0, 31));
            #2;
            check($sformatf("rnd%0d_rd1_x%0d", n, rs1), rdout1,
                  model_read(rs1, rst, we, wraddr, wrdata));
            check($sformatf("rnd%0d_rd2_x%0d", n, rs2), rdout2,
                  model_read(rs2, rst, we, wraddr, wrdata));
            if (rst) begin
                for (int a = 0; a < 32; a++) model[a] = 32'h0;
            end else if (we && wraddr != 5'd0) begin
                model[wraddr] = wrdata;
            end
            @(posedge clk); #1;
        end

        // Final sweep: every register matches the model.
        rst = 1'b0; we = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rs1 = 5'(a); rs2 = 5'(a);
            #1;
            check($sformatf("final_rd1_x%0d", a), rdout1, (a == 0) ? 32'h0 : model[a]);
            check($sformatf("final_rd2_x%0d", a), rdout2, (a == 0) ? 32'h0 : model[a]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_file
